hazard_sb: RTL and testbench

HAZARD_SB -- requirements
Module: hazard_sb

---
 rtl/hazard_sb.sv | 175 +++++++++++++++++
 tb/tb_hazard_sb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sb.sv
// hazard_sb: ID-stage hazard scoreboard for an in-order pipeline.
// Tracks in-flight register writers in EX..WB, detects RAW hazards and
// multi-cycle EX occupancy, and produces issue/stall/bubble/flush control.
// Optional feature: define HAZARD_SB_FWD_EN to forward from in-flight stages
// instead of stalling; only a load still in EX then forces a stall.
module hazard_sb #(
  parameter int NREG  = 32,
  parameter int DEPTH = 3,
  parameter int LATW  = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [$clog2(NREG)-1:0]    id_ra1,
  input  logic [$clog2(NREG)-1:0]    id_ra2,
  input  logic                       id_use1,
  input  logic                       id_use2,
  input  logic                       id_wen,
  input  logic [$clog2(NREG)-1:0]    id_dst,
  input  logic                       id_load,
  input  logic                       id_multi,
  input  logic [LATW-1:0]            id_lat,
  input  logic                       iwait,
  input  logic                       dwait,
  input  logic                       redirect,
  output logic                       issue,
  output logic                       stall_if,
  output logic                       bubble_ex,
  output logic                       flush_if_id,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel1,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel2,
  output logic                       mdu_busy,
  output logic [NREG-1:0]            pend
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH+1);

  // Tracker entry k describes the instruction currently in stage k (1 = EX).
  logic            trk_vld_q [1:DEPTH];
  logic            trk_vld_d [1:DEPTH];
  logic [AW-1:0]   trk_dst_q [1:DEPTH];
  logic [AW-1:0]   trk_dst_d [1:DEPTH];
`ifdef HAZARD_SB_FWD_EN
  logic            trk_ld_q  [1:DEPTH];
  logic            trk_ld_d  [1:DEPTH];
  logic            ld1, ld2;
`endif
  logic [LATW-1:0] cnt_q, cnt_d;
  // A redirect seen while dmem is stalled is remembered so the flush is
  // still applied on the cycle the pipeline can actually move again.
  logic            redir_hold_q, redir_hold_d;

  logic [SW-1:0]   m1, m2;
  logic            hazard_stall;
  logic            redir_eff;
  logic            advance;

  // Youngest matching producer per source; scanning oldest-first lets the youngest win.
  always_comb begin
    m1 = '0;
    m2 = '0;
`ifdef HAZARD_SB_FWD_EN
    ld1 = 1'b0;
    ld2 = 1'b0;
`endif
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_use1 && (id_ra1 != '0) && trk_vld_q[k] && (trk_dst_q[k] == id_ra1)) begin
        m1 = SW'(k);
`ifdef HAZARD_SB_FWD_EN
        ld1 = trk_ld_q[k];
`endif
      end
      if (id_use2 && (id_ra2 != '0) && trk_vld_q[k] && (trk_dst_q[k] == id_ra2)) begin
        m2 = SW'(k);
`ifdef HAZARD_SB_FWD_EN
        ld2 = trk_ld_q[k];
`endif
      end
    end
  end

`ifdef HAZARD_SB_FWD_EN
  // Forward every match; only a load still in EX has no data yet (load-use).
  always_comb begin
    hazard_stall = ((m1 == SW'(1)) && ld1) || ((m2 == SW'(1)) && ld2);
    fwd_sel1     = (reset && id_valid) ? m1 : '0;
    fwd_sel2     = (reset && id_valid) ? m2 : '0;
  end
`else
  logic unused_load;
  assign unused_load = id_load;

  // Without forwarding any in-flight producer of a source holds ID.
  always_comb begin
    hazard_stall = (m1 != '0) || (m2 != '0);
    fwd_sel1     = '0;
    fwd_sel2     = '0;
  end
`endif

  // Pipeline control; everything is forced quiet while reset is held.
  always_comb begin
    mdu_busy    = reset & (cnt_q != '0);
    redir_eff   = redirect | redir_hold_q;
    issue       = reset & id_valid & ~hazard_stall & ~iwait & ~dwait & ~mdu_busy & ~redir_eff;
    stall_if    = reset & id_valid & ~issue & ~redir_eff;
    bubble_ex   = reset & ~issue & ~(dwait | mdu_busy);
    flush_if_id = reset & redir_eff;
    advance     = ~dwait & ~mdu_busy;
  end

  // Next tracker contents, latency countdown and held redirect.
  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      trk_vld_d[k] = trk_vld_q[k];
      trk_dst_d[k] = trk_dst_q[k];
`ifdef HAZARD_SB_FWD_EN
      trk_ld_d[k]  = trk_ld_q[k];
`endif
    end
    if (advance) begin
      for (int k = DEPTH; k >= 2; k--) begin
        trk_vld_d[k] = trk_vld_q[k-1];
        trk_dst_d[k] = trk_dst_q[k-1];
`ifdef HAZARD_SB_FWD_EN
        trk_ld_d[k]  = trk_ld_q[k-1];
`endif
      end
      // x0 writes and non-writers never become pending.
      trk_vld_d[1] = issue & id_wen & (id_dst != '0);
      trk_dst_d[1] = id_dst;
`ifdef HAZARD_SB_FWD_EN
      trk_ld_d[1]  = id_load;
`endif
    end

    cnt_d = cnt_q;
    if (cnt_q != '0) cnt_d = cnt_q - LATW'(1);
    if (issue && id_multi && (id_lat != '0)) cnt_d = id_lat;

    redir_hold_d = redir_eff & dwait;
  end

  // Control state with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= DEPTH; k++) trk_vld_q[k] <= 1'b0;
      cnt_q        <= '0;
      redir_hold_q <= 1'b0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) trk_vld_q[k] <= trk_vld_d[k];
      cnt_q        <= cnt_d;
      redir_hold_q <= redir_hold_d;
    end
  end

  // Tracker payload; only meaningful when the matching valid is set.
  always_ff @(posedge clk) begin
    for (int k = 1; k <= DEPTH; k++) begin
      trk_dst_q[k] <= trk_dst_d[k];
`ifdef HAZARD_SB_FWD_EN
      trk_ld_q[k]  <= trk_ld_d[k];
`endif
    end
  end

  // Pending-write bitmap derived from valid tracker entries.
  always_comb begin
    pend = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (trk_vld_q[k] && (trk_dst_q[k] != '0)) pend[trk_dst_q[k]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_hazard_sb;
  localparam int NREG  = 32;
  localparam int DEPTH = 3;
  localparam int LATW  = 6;
  localparam int AW    = $clog2(NREG);
`ifdef HAZARD_SB_FWD_EN
  localparam bit FWD      = 1'b1;
  localparam int A_STALLS = 0;
  localparam int A_FWD    = 1;
  localparam int B_STALLS = 1;
  localparam int B_FWD    = 2;
`else
  localparam bit FWD      = 1'b0;
  localparam int A_STALLS = 3;
  localparam int A_FWD    = 0;
  localparam int B_STALLS = 3;
  localparam int B_FWD    = 0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            id_valid = 1'b0;
  logic [AW-1:0]   id_ra1 = '0, id_ra2 = '0, id_dst = '0;
  logic            id_use1 = 1'b0, id_use2 = 1'b0, id_wen = 1'b0;
  logic            id_load = 1'b0, id_multi = 1'b0;
  logic [LATW-1:0] id_lat = '0;
  logic            iwait = 1'b0, dwait = 1'b0, redirect = 1'b0;
  logic            issue, stall_if, bubble_ex, flush_if_id, mdu_busy;
  logic [$clog2(DEPTH+1)-1:0] fwd_sel1, fwd_sel2;
  logic [NREG-1:0] pend;

  hazard_sb #(.NREG(NREG), .DEPTH(DEPTH), .LATW(LATW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_ra1(id_ra1), .id_ra2(id_ra2), .id_use1(id_use1), .id_use2(id_use2),
    .id_wen(id_wen), .id_dst(id_dst), .id_load(id_load), .id_multi(id_multi),
    .id_lat(id_lat), .iwait(iwait), .dwait(dwait), .redirect(redirect),
    .issue(issue), .stall_if(stall_if), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .mdu_busy(mdu_busy), .pend(pend)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int stage; int dst; bit ld; } wr_t;
  wr_t inflight[$];
  int  busy_left = 0;
  bit  hold = 1'b0;

  task automatic src_match(input bit u, input int ra, output int stg, output bit ld);
    stg = 0;
    ld  = 1'b0;
    if (u && ra != 0) begin
      foreach (inflight[i]) begin
        if (inflight[i].dst == ra && (stg == 0 || inflight[i].stage < stg)) begin
          stg = inflight[i].stage;
          ld  = inflight[i].ld;
        end
      end
    end
  endtask

  task automatic model_eval(output bit o_issue, output bit o_stall, output bit o_bub,
                            output bit o_flush, output bit o_busy, output int o_f1,
                            output int o_f2, output logic [NREG-1:0] o_pend);
    int s1, s2;
    bit l1, l2, hz, red;
    src_match(id_use1, int'(id_ra1), s1, l1);
    src_match(id_use2, int'(id_ra2), s2, l2);
    if (FWD) hz = (s1 == 1 && l1) || (s2 == 1 && l2);
    else     hz = (s1 != 0) || (s2 != 0);
    o_busy  = (busy_left != 0);
    red     = redirect || hold;
    o_issue = id_valid && !hz && !iwait && !dwait && !o_busy && !red;
    o_stall = id_valid && !o_issue && !red;
    o_bub   = !o_issue && !(dwait || o_busy);
    o_flush = red;
    o_f1    = (FWD && id_valid) ? s1 : 0;
    o_f2    = (FWD && id_valid) ? s2 : 0;
    o_pend  = '0;
    foreach (inflight[i]) o_pend[inflight[i].dst] = 1'b1;
    if (!reset) begin
      o_issue = 0; o_stall = 0; o_bub = 0; o_flush = 0; o_busy = 0;
      o_f1 = 0; o_f2 = 0; o_pend = '0;
    end
  endtask

  // Model state update on every clock edge, cleared immediately by reset.
  initial forever begin
    bit ei, es, eb, ef, ebusy;
    int f1, f2;
    logic [NREG-1:0] ep;
    wr_t w;
    @(posedge clk or negedge reset);
    if (!reset) begin
      inflight.delete();
      busy_left = 0;
      hold = 1'b0;
    end else begin
      model_eval(ei, es, eb, ef, ebusy, f1, f2, ep);
      if (!dwait && !ebusy) begin
        foreach (inflight[i]) inflight[i].stage++;
        while (inflight.size() > 0 && inflight[0].stage > DEPTH) void'(inflight.pop_front());
        if (ei && id_wen && id_dst != 0) begin
          w.stage = 1; w.dst = int'(id_dst); w.ld = id_load;
          inflight.push_back(w);
        end
      end
      if (busy_left > 0) busy_left--;
      if (ei && id_multi && id_lat != 0) busy_left = int'(id_lat);
      hold = (redirect || hold) && dwait;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    bit ei, es, eb, ef, ebusy;
    int f1, f2;
    logic [NREG-1:0] ep;
    @(negedge clk);
    model_eval(ei, es, eb, ef, ebusy, f1, f2, ep);
    chk("cmp_issue", issue, ei);
    chk("cmp_stall_if", stall_if, es);
    chk("cmp_bubble_ex", bubble_ex, eb);
    chk("cmp_flush", flush_if_id, ef);
    chk("cmp_mdu_busy", mdu_busy, ebusy);
    chk("cmp_fwd1", fwd_sel1, f1);
    chk("cmp_fwd2", fwd_sel2, f2);
    chk("cmp_pend", pend, ep);
  end

  // ---------------- stimulus ----------------
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use1 = 0; id_use2 = 0; id_wen = 0; id_load = 0; id_multi = 0;
    id_ra1 = '0; id_ra2 = '0; id_dst = '0; id_lat = '0;
    iwait = 0; dwait = 0; redirect = 0;
  endtask

  task automatic ins(input int dst, input bit wen, input int ra1, input bit u1,
                     input int ra2, input bit u2, input bit ld, input bit mul, input int lat);
    id_valid = 1; id_dst = AW'(dst); id_wen = wen;
    id_ra1 = AW'(ra1); id_use1 = u1; id_ra2 = AW'(ra2); id_use2 = u2;
    id_load = ld; id_multi = mul; id_lat = LATW'(lat);
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    while (!issue && n < 12) begin
      n++;
      go();
      #2;
    end
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + 1) go();
    #2;
    chk("drain_pend", pend, 0);
  endtask

  initial begin
    int n;
    idle();
    reset = 0;
    repeat (2) go();
    #2;
    chk("rst_issue", issue, 0);
    chk("rst_stall", stall_if, 0);
    chk("rst_bubble", bubble_ex, 0);
    chk("rst_flush", flush_if_id, 0);
    chk("rst_busy", mdu_busy, 0);
    chk("rst_fwd1", fwd_sel1, 0);
    chk("rst_pend", pend, 0);
    go(); reset = 1; #2;
    chk("idle_bubble", bubble_ex, 1);

    // ADDI x5 then ADD x6,x5,x0
    go(); ins(5, 1, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("a_addi_issue", issue, 1);
    go(); ins(6, 1, 5, 1, 0, 1, 0, 0, 0); #2;
    chk("a_pend5", pend[5], 1);
    wait_issue(n);
    chk("a_stalls", n, A_STALLS);
    chk("a_fwd1", fwd_sel1, A_FWD);
    chk("a_fwd2", fwd_sel2, 0);
    drain();

    // x0 destination and non-writing instruction never become pending
    go(); ins(0, 1, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("x0_issue", issue, 1);
    go(); ins(9, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    go(); idle(); #2;
    chk("x0_nowen_pend", pend, 0);

    // LD x7 then ADD x8,x7,x7
    go(); ins(7, 1, 0, 0, 0, 0, 1, 0, 0); #2;
    chk("b_ld_issue", issue, 1);
    go(); ins(8, 1, 7, 1, 7, 1, 0, 0, 0); #2;
    chk("b_bubble", bubble_ex, 1);
    chk("b_stall", stall_if, 1);
    wait_issue(n);
    chk("b_stalls", n, B_STALLS);
    chk("b_fwd1", fwd_sel1, B_FWD);
    chk("b_fwd2", fwd_sel2, B_FWD);
    drain();

    // DIV lat=5 then independent ADD
    go(); ins(10, 1, 0, 0, 0, 0, 0, 1, 5); #2;
    chk("c_div_issue", issue, 1);
    go(); ins(11, 1, 1, 1, 2, 1, 0, 0, 0); #2;
    chk("c_bubble", bubble_ex, 0);
    chk("c_stall", stall_if, 1);
    chk("c_pend10", pend[10], 1);
    n = 0;
    while (mdu_busy && n < 12) begin
      n++;
      go();
      #2;
    end
    chk("c_busy_cycles", n, 5);
    chk("c_add_issue", issue, 1);
    drain();

    // dwait for 4 cycles with x3 at stage 2
    go(); ins(3, 1, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("d_writer_issue", issue, 1);
    go(); idle();
    go(); ins(12, 1, 1, 1, 0, 0, 0, 0, 0); dwait = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("d_pend3", pend[3], 1);
      chk("d_bubble", bubble_ex, 0);
      chk("d_issue", issue, 0);
      if (i < 3) go();
    end
    go(); dwait = 0; #2;
    chk("d_pend3_after", pend[3], 1);
    chk("d_issue_after", issue, 1);
    drain();

    // redirect while stalled on a load hazard, then redirect under dwait
    go(); ins(4, 1, 0, 0, 0, 0, 1, 0, 0); #2;
    chk("e_ld_issue", issue, 1);
    go(); ins(13, 1, 4, 1, 0, 0, 0, 0, 0); #2;
    chk("e_stall", stall_if, 1);
    redirect = 1; #1;
    chk("e_flush", flush_if_id, 1);
    chk("e_issue", issue, 0);
    chk("e_stall_red", stall_if, 0);
    go(); idle(); redirect = 1; dwait = 1; #2;
    chk("e_flush_dw", flush_if_id, 1);
    go(); redirect = 0; #2;
    chk("e_flush_hold", flush_if_id, 1);
    go(); dwait = 0; #2;
    chk("e_flush_release", flush_if_id, 1);
    go(); #2;
    chk("e_flush_clear", flush_if_id, 0);
    drain();

    // reset during mdu_busy
    go(); ins(10, 1, 0, 0, 0, 0, 0, 1, 5); #2;
    chk("f_div_issue", issue, 1);
    go(); idle(); #2;
    chk("f_busy", mdu_busy, 1);
    chk("f_pend10", pend[10], 1);
    #1; reset = 0; #1;
    chk("f_rst_pend", pend, 0);
    chk("f_rst_busy", mdu_busy, 0);
    chk("f_rst_issue", issue, 0);
    chk("f_rst_bubble", bubble_ex, 0);
    go(); go(); reset = 1; ins(14, 1, 10, 1, 0, 0, 0, 0, 0); #2;
    chk("f_issue", issue, 1);
    chk("f_stall", stall_if, 0);
    chk("f_fwd1", fwd_sel1, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end, actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
